// File: rtl/imu_bias_cal.sv
// imu_bias_cal: gyro bias calibration and correction between the SPI IMU
// driver and the attitude-fusion FSM.
//
// After reset or a recal pulse the block discards SETTLE samples, then
// averages 2^CAL_LOG2 stationary gyro samples per axis to estimate the bias.
// Any gyro axis with |v| > MOTION_THR during averaging restarts the average.
// Once calibrated, every sample set is forwarded one cycle after in_valid.
// Each gyro axis is corrected by sat(in - bias).
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   recal                pulse; restart calibration (wins over in_valid)
//   in_valid             pulse; the six *_in samples are valid
//   accel_*_in, gyro_*_in  raw signed W-bit samples
//   out_valid            pulse; corrected set valid (latency 1)
//   accel_*, gyro_*      registered outputs, held between pulses
//   cal_done             bias valid and correction active
//   motion_cnt           motion restarts since last calibration start (sat 255)
//
// Optional feature, macro IMU_ACCEL_BIAS_EN: accel x/y are averaged as well
// and corrected the same way as the gyro. accel_z carries gravity and is
// always passed through unchanged. When the macro is undefined, no accel
// accumulators exist and the accel outputs are registered copies.
//
// Limitation: an in_valid arriving in the single bias-compute cycle is
// dropped. This cannot happen at the driver's 100 Hz sample rate.

module imu_bias_cal #(
  parameter int unsigned W          = 16,
  parameter int unsigned CAL_LOG2   = 6,
  parameter int unsigned SETTLE     = 8,
  parameter int unsigned MOTION_THR = 500
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         recal,
  input  logic         in_valid,
  input  logic [W-1:0] accel_x_in,
  input  logic [W-1:0] accel_y_in,
  input  logic [W-1:0] accel_z_in,
  input  logic [W-1:0] gyro_x_in,
  input  logic [W-1:0] gyro_y_in,
  input  logic [W-1:0] gyro_z_in,
  output logic         out_valid,
  output logic [W-1:0] accel_x,
  output logic [W-1:0] accel_y,
  output logic [W-1:0] accel_z,
  output logic [W-1:0] gyro_x,
  output logic [W-1:0] gyro_y,
  output logic [W-1:0] gyro_z,
  output logic         cal_done,
  output logic [7:0]   motion_cnt
);

  localparam int unsigned AW = W + CAL_LOG2;
  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned CW = (CAL_LOG2 > 0) ? CAL_LOG2 : 1;
`ifdef IMU_ACCEL_BIAS_EN
  localparam int unsigned NACC = 5;  // gyro x/y/z, accel x/y
`else
  localparam int unsigned NACC = 3;  // gyro x/y/z
`endif

  typedef enum logic [1:0] {
    S_SETTLE = 2'd0,
    S_ACCUM  = 2'd1,
    S_BIAS   = 2'd2,
    S_APPLY  = 2'd3
  } state_e;

  // With no settle window, calibration starts accumulating immediately.
  localparam state_e S_START = (SETTLE == 0) ? S_ACCUM : S_SETTLE;

  state_e                  state_q, state_d;
  logic [SW-1:0]           settle_cnt_q, settle_cnt_d;
  logic [CW-1:0]           samp_cnt_q, samp_cnt_d;
  logic [NACC-1:0][AW-1:0] acc_q, acc_d;
  logic [NACC-1:0][W-1:0]  bias_q, bias_d;
  logic [7:0]              motion_cnt_q, motion_cnt_d;
  logic                    cal_done_q, cal_done_d;
  logic                    out_valid_q, out_valid_d;
  logic [2:0][W-1:0]       gyro_q, gyro_d;
  logic [2:0][W-1:0]       accel_q, accel_d;

  logic [2:0][W-1:0]       gyro_in_c;
  logic [2:0][W-1:0]       accel_in_c;
  logic [NACC-1:0][W-1:0]  samp_c;
  logic                    motion_c;

  // |v| > MOTION_THR, with |v| taken in W+1 bits so the most negative value works.
  function automatic logic over_thr(input logic [W-1:0] v);
    logic [W:0] ext;
    logic [W:0] mag;
    ext = {v[W-1], v};
    mag = v[W-1] ? (~ext + (W+1)'(1)) : ext;
    return mag > (W+1)'(MOTION_THR);
  endfunction

  // a - b in W+1 bits, clamped to the signed W-bit range.
  function automatic logic [W-1:0] sat_sub(input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W:0] diff;
    diff = {a[W-1], a} - {b[W-1], b};
    if (diff[W] != diff[W-1]) begin
      return diff[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
    return diff[W-1:0];
  endfunction

  assign gyro_in_c  = {gyro_z_in, gyro_y_in, gyro_x_in};
  assign accel_in_c = {accel_z_in, accel_y_in, accel_x_in};

  // Samples feeding the accumulators; motion is judged on the gyro only.
  always_comb begin
    samp_c   = '0;
    motion_c = 1'b0;
    for (int i = 0; i < 3; i++) begin
      samp_c[i] = gyro_in_c[i];
      motion_c  = motion_c | over_thr(gyro_in_c[i]);
    end
`ifdef IMU_ACCEL_BIAS_EN
    samp_c[3] = accel_in_c[0];
    samp_c[4] = accel_in_c[1];
`endif
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    samp_cnt_d   = samp_cnt_q;
    acc_d        = acc_q;
    bias_d       = bias_q;
    motion_cnt_d = motion_cnt_q;
    cal_done_d   = cal_done_q;
    out_valid_d  = 1'b0;
    gyro_d       = gyro_q;
    accel_d      = accel_q;

    if (recal) begin
      // Biases are kept but unused until the new calibration completes.
      state_d      = S_START;
      settle_cnt_d = '0;
      samp_cnt_d   = '0;
      acc_d        = '0;
      motion_cnt_d = '0;
      cal_done_d   = 1'b0;
    end else begin
      case (state_q)
        S_SETTLE: begin
          if (in_valid) begin
            if (settle_cnt_q == SW'(SETTLE - 1)) begin
              settle_cnt_d = '0;
              state_d      = S_ACCUM;
            end else begin
              settle_cnt_d = settle_cnt_q + SW'(1);
            end
          end
        end

        S_ACCUM: begin
          if (in_valid) begin
            if (motion_c) begin
              acc_d      = '0;
              samp_cnt_d = '0;
              if (motion_cnt_q != 8'hFF) begin
                motion_cnt_d = motion_cnt_q + 8'd1;
              end
            end else begin
              for (int i = 0; i < NACC; i++) begin
                acc_d[i] = acc_q[i] + AW'($signed(samp_c[i]));
              end
              samp_cnt_d = samp_cnt_q + CW'(1);
              if (samp_cnt_q == CW'(2**CAL_LOG2 - 1)) begin
                samp_cnt_d = '0;
                state_d    = S_BIAS;
              end
            end
          end
        end

        S_BIAS: begin
          // Taking the upper W bits is an arithmetic shift right by CAL_LOG2 (floor).
          for (int i = 0; i < NACC; i++) begin
            bias_d[i] = acc_q[i][CAL_LOG2 +: W];
          end
          acc_d      = '0;
          cal_done_d = 1'b1;
          state_d    = S_APPLY;
        end

        S_APPLY: begin
          if (in_valid) begin
            out_valid_d = 1'b1;
            for (int i = 0; i < 3; i++) begin
              gyro_d[i] = sat_sub(gyro_in_c[i], bias_q[i]);
            end
            accel_d = accel_in_c;
`ifdef IMU_ACCEL_BIAS_EN
            accel_d[0] = sat_sub(accel_in_c[0], bias_q[3]);
            accel_d[1] = sat_sub(accel_in_c[1], bias_q[4]);
`endif
          end
        end

        default: state_d = S_START;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_START;
      settle_cnt_q <= '0;
      samp_cnt_q   <= '0;
      acc_q        <= '0;
      bias_q       <= '0;
      motion_cnt_q <= '0;
      cal_done_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      gyro_q       <= '0;
      accel_q      <= '0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      samp_cnt_q   <= samp_cnt_d;
      acc_q        <= acc_d;
      bias_q       <= bias_d;
      motion_cnt_q <= motion_cnt_d;
      cal_done_q   <= cal_done_d;
      out_valid_q  <= out_valid_d;
      gyro_q       <= gyro_d;
      accel_q      <= accel_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign gyro_x     = gyro_q[0];
  assign gyro_y     = gyro_q[1];
  assign gyro_z     = gyro_q[2];
  assign accel_x    = accel_q[0];
  assign accel_y    = accel_q[1];
  assign accel_z    = accel_q[2];
  assign cal_done   = cal_done_q;
  assign motion_cnt = motion_cnt_q;

endmodule
